// File: rtl/sdram_port_arbiter.sv
// Burst-granular round-robin arbiter sharing one SDRAM controller port among
// the flash boot loader (port 0) and the cache fill/writeback engines.
module sdram_port_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int DRAM_ADDR_WIDTH = 22,
    parameter int DRAM_DATA_WIDTH = 32
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Reset,
    input  logic                                 i_Boot_Done,
    input  logic [NUM_REQ-1:0]                   i_Req_Valid,
    input  logic [NUM_REQ-1:0]                   i_Req_Read_Write_n,
    input  logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0]   i_Req_Addr,
    input  logic [NUM_REQ*DRAM_DATA_WIDTH-1:0]   i_Req_Data,
    output logic [NUM_REQ-1:0]                   o_Req_Data_Read,
    output logic [NUM_REQ-1:0]                   o_Req_Last,
    output logic [NUM_REQ-1:0]                   o_Req_Rd_Valid,
    output logic [DRAM_DATA_WIDTH-1:0]           o_Req_Rd_Data,
    output logic [NUM_REQ-1:0]                   o_Grant,
    output logic [DRAM_ADDR_WIDTH-1:0]           o_SDRAM_Addr,
    output logic                                 o_SDRAM_Req_Valid,
    output logic                                 o_SDRAM_Read_Write_n,
    output logic [DRAM_DATA_WIDTH-1:0]           o_SDRAM_Data,
    input  logic                                 i_SDRAM_Data_Read,
    input  logic                                 i_SDRAM_Last,
    input  logic                                 i_SDRAM_Rd_Valid,
    input  logic [DRAM_DATA_WIDTH-1:0]           i_SDRAM_Rd_Data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 found;
    logic [PTR_W-1:0]     pick;
    logic [PTR_W-1:0]     scanIdx;

    // Until the boot loader finishes, only port 0 may compete.
    always_comb begin
        eligible = i_Req_Valid;
        if (!i_Boot_Done) begin
            eligible = i_Req_Valid & {{(NUM_REQ-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        found   = 1'b0;
        pick    = ptr_q;
        scanIdx = ptr_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            scanIdx = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!found && eligible[scanIdx]) begin
                found = 1'b1;
                pick  = scanIdx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    ptr_d         = pick;
                    state_d       = BURST;
                end
            end
            BURST: begin
                if (i_SDRAM_Last) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Downstream muxes and upstream strobes are live only while a burst is owned.
    always_comb begin
        o_SDRAM_Req_Valid    = 1'b0;
        o_SDRAM_Addr         = '0;
        o_SDRAM_Read_Write_n = 1'b0;
        o_SDRAM_Data         = '0;
        o_Req_Data_Read      = '0;
        o_Req_Last           = '0;
        o_Req_Rd_Valid       = '0;
        if (state_q == BURST) begin
            o_SDRAM_Req_Valid = |(i_Req_Valid & grant_q);
            o_Req_Data_Read   = grant_q & {NUM_REQ{i_SDRAM_Data_Read}};
            o_Req_Last        = grant_q & {NUM_REQ{i_SDRAM_Last}};
            o_Req_Rd_Valid    = grant_q & {NUM_REQ{i_SDRAM_Rd_Valid}};
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant_q[k]) begin
                    o_SDRAM_Addr         = i_Req_Addr[k*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
                    o_SDRAM_Read_Write_n = i_Req_Read_Write_n[k];
                    o_SDRAM_Data         = i_Req_Data[k*DRAM_DATA_WIDTH +: DRAM_DATA_WIDTH];
                end
            end
        end
    end

    assign o_Grant       = grant_q;
    assign o_Req_Rd_Data = i_SDRAM_Rd_Data;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_sdram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clock;
    logic            reset;
    logic            bootDone;
    logic [N-1:0]    reqValid;
    logic [N-1:0]    reqRw;
    logic [N*AW-1:0] reqAddr;
    logic [N*DW-1:0] reqData;
    logic [N-1:0]    reqDataRead;
    logic [N-1:0]    reqLast;
    logic [N-1:0]    reqRdValid;
    logic [DW-1:0]   reqRdData;
    logic [N-1:0]    grant;
    logic [AW-1:0]   sdramAddr;
    logic            sdramReqValid;
    logic            sdramRw;
    logic [DW-1:0]   sdramDataOut;
    logic            sdramDataRead;
    logic            sdramLast;
    logic            sdramRdValid;
    logic [DW-1:0]   sdramRdData;

    logic [AW-1:0]   portAddr [N];
    logic [DW-1:0]   portData [N];

    int checks;
    int errors;

    sdram_port_arbiter #(.NUM_REQ(N), .DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) dut (
        .i_Clk                (clock),
        .i_Reset              (reset),
        .i_Boot_Done          (bootDone),
        .i_Req_Valid          (reqValid),
        .i_Req_Read_Write_n   (reqRw),
        .i_Req_Addr           (reqAddr),
        .i_Req_Data           (reqData),
        .o_Req_Data_Read      (reqDataRead),
        .o_Req_Last           (reqLast),
        .o_Req_Rd_Valid       (reqRdValid),
        .o_Req_Rd_Data        (reqRdData),
        .o_Grant              (grant),
        .o_SDRAM_Addr         (sdramAddr),
        .o_SDRAM_Req_Valid    (sdramReqValid),
        .o_SDRAM_Read_Write_n (sdramRw),
        .o_SDRAM_Data         (sdramDataOut),
        .i_SDRAM_Data_Read    (sdramDataRead),
        .i_SDRAM_Last         (sdramLast),
        .i_SDRAM_Rd_Valid     (sdramRdValid),
        .i_SDRAM_Rd_Data      (sdramRdData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic          boot;
        logic [N-1:0]  valid;
        logic [N-1:0]  rw;
        logic          dRead;
        logic          last;
        logic          rdV;
        logic [DW-1:0] rdData;
        logic [N-1:0]  expGrant;
        logic          expSValid;
        logic [N-1:0]  expDRead;
        logic [N-1:0]  expLast;
        logic [N-1:0]  expRdV;
        logic          inBurst;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: current owner (-1 = none), release cycle flag, last winner.
    int mOwner;
    bit mRelease;
    int mLastWin;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic boot, input logic [N-1:0] valid, input logic [N-1:0] rw,
                                 input logic dRead, input logic last, input logic rdV,
                                 input logic [DW-1:0] rdData);
        bootDone      = boot;
        reqValid      = valid;
        reqRw         = rw;
        sdramDataRead = dRead;
        sdramLast     = last;
        sdramRdValid  = rdV;
        sdramRdData   = rdData;
        for (int k = 0; k < N; k++) begin
            reqAddr[k*AW +: AW] = portAddr[k];
            reqData[k*DW +: DW] = portData[k];
        end
    endtask

    task automatic addVec(input logic boot, input logic [N-1:0] valid, input logic [N-1:0] rw,
                          input logic dRead, input logic last, input logic rdV, input logic [DW-1:0] rdData,
                          input logic [N-1:0] eG, input logic eSV, input logic [N-1:0] eDR,
                          input logic [N-1:0] eL, input logic [N-1:0] eRV, input logic inB);
        vec_t v;
        v = '{boot, valid, rw, dRead, last, rdV, rdData, eG, eSV, eDR, eL, eRV, inB};
        vecs.push_back(v);
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        mOwner   = -1;
        mRelease = 1'b0;
        mLastWin = N - 1;
    endtask

    // Model: expected outputs for the current cycle, checked, then advanced one clock.
    task automatic modelCycle();
        logic [N-1:0] eG, eDR, eL, eRV;
        logic eSV;
        int best, bestDist, d;
        eG = '0; eDR = '0; eL = '0; eRV = '0; eSV = 1'b0;
        if (mOwner >= 0) eG[mOwner] = 1'b1;
        if (mOwner >= 0 && !mRelease) begin
            eSV          = reqValid[mOwner];
            eDR[mOwner]  = sdramDataRead;
            eL[mOwner]   = sdramLast;
            eRV[mOwner]  = sdramRdValid;
            checkOutput("rnd_addr", 64'(sdramAddr), 64'(portAddr[mOwner]));
            checkOutput("rnd_rw",   64'(sdramRw),   64'(reqRw[mOwner]));
            checkOutput("rnd_data", 64'(sdramDataOut), 64'(portData[mOwner]));
        end
        checkOutput("rnd_grant",  64'(grant),         64'(eG));
        checkOutput("rnd_svalid", 64'(sdramReqValid), 64'(eSV));
        checkOutput("rnd_dread",  64'(reqDataRead),   64'(eDR));
        checkOutput("rnd_last",   64'(reqLast),       64'(eL));
        checkOutput("rnd_rdv",    64'(reqRdValid),    64'(eRV));
        checkOutput("rnd_rddata", 64'(reqRdData),     64'(sdramRdData));
        if (mRelease) begin
            mOwner   = -1;
            mRelease = 1'b0;
        end else if (mOwner >= 0) begin
            if (sdramLast) mRelease = 1'b1;
        end else begin
            best = -1;
            bestDist = N + 1;
            for (int k = 0; k < N; k++) begin
                if (reqValid[k] && (bootDone || k == 0)) begin
                    d = (k - mLastWin - 1 + 2 * N) % N;
                    if (d < bestDist) begin
                        bestDist = d;
                        best = k;
                    end
                end
            end
            if (best >= 0) begin
                mOwner   = best;
                mLastWin = best;
            end
        end
    endtask

    initial begin
        int owner;
        int afterLast [N];
        logic [N-1:0] rv;
        logic [N-1:0] got;
        bit found;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        portAddr[0] = 22'h000100; portData[0] = 32'hA000_0000;
        portAddr[1] = 22'h000200; portData[1] = 32'hA000_0001;
        portAddr[2] = 22'h000040; portData[2] = 32'hA000_0002;
        applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, '0);

        // Write burst on port 2, strobes outside BURST must be dropped.
        addVec(1, 3'b100, 3'b000, 0, 0, 0, 32'h0, 3'b000, 0, 3'b000, 3'b000, 3'b000, 0);
        addVec(1, 3'b100, 3'b000, 1, 0, 0, 32'h0, 3'b100, 1, 3'b100, 3'b000, 3'b000, 1);
        addVec(1, 3'b100, 3'b000, 1, 0, 0, 32'h0, 3'b100, 1, 3'b100, 3'b000, 3'b000, 1);
        addVec(1, 3'b100, 3'b000, 1, 0, 0, 32'h0, 3'b100, 1, 3'b100, 3'b000, 3'b000, 1);
        addVec(1, 3'b100, 3'b000, 0, 1, 0, 32'h0, 3'b100, 1, 3'b000, 3'b100, 3'b000, 1);
        addVec(1, 3'b100, 3'b000, 1, 1, 1, 32'h0, 3'b100, 0, 3'b000, 3'b000, 3'b000, 0);
        addVec(1, 3'b000, 3'b000, 1, 0, 1, 32'h0, 3'b000, 0, 3'b000, 3'b000, 3'b000, 0);
        // Read burst on port 1.
        addVec(1, 3'b010, 3'b010, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 3'b000, 0);
        addVec(1, 3'b010, 3'b010, 0, 0, 1, 32'hDEADBEE0, 3'b010, 1, 3'b000, 3'b000, 3'b010, 1);
        addVec(1, 3'b010, 3'b010, 0, 0, 1, 32'hDEADBEE1, 3'b010, 1, 3'b000, 3'b000, 3'b010, 1);
        addVec(1, 3'b010, 3'b010, 0, 0, 1, 32'hDEADBEE2, 3'b010, 1, 3'b000, 3'b000, 3'b010, 1);
        addVec(1, 3'b010, 3'b010, 0, 1, 1, 32'hDEADBEE3, 3'b010, 1, 3'b000, 3'b010, 3'b010, 1);
        addVec(1, 3'b010, 3'b010, 0, 0, 0, 32'h0,        3'b010, 0, 3'b000, 3'b000, 3'b000, 0);
        addVec(1, 3'b000, 3'b000, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 3'b000, 0);
        // Boot gating: port 1 waits, port 0 wins, boot rises mid-burst.
        addVec(0, 3'b010, 3'b000, 0, 0, 0, 32'h0, 3'b000, 0, 3'b000, 3'b000, 3'b000, 0);
        addVec(0, 3'b011, 3'b000, 0, 0, 0, 32'h0, 3'b000, 0, 3'b000, 3'b000, 3'b000, 0);
        addVec(0, 3'b011, 3'b000, 0, 0, 0, 32'h0, 3'b001, 1, 3'b000, 3'b000, 3'b000, 1);
        addVec(1, 3'b011, 3'b000, 0, 0, 0, 32'h0, 3'b001, 1, 3'b000, 3'b000, 3'b000, 1);
        addVec(1, 3'b011, 3'b000, 0, 1, 0, 32'h0, 3'b001, 1, 3'b000, 3'b001, 3'b000, 1);
        addVec(1, 3'b011, 3'b000, 0, 0, 0, 32'h0, 3'b001, 0, 3'b000, 3'b000, 3'b000, 0);
        addVec(1, 3'b010, 3'b000, 0, 0, 0, 32'h0, 3'b000, 0, 3'b000, 3'b000, 3'b000, 0);
        // Port 1 owns, then drops valid before Last.
        addVec(1, 3'b010, 3'b000, 0, 0, 0, 32'h0, 3'b010, 1, 3'b000, 3'b000, 3'b000, 1);
        addVec(1, 3'b000, 3'b000, 0, 0, 0, 32'h0, 3'b010, 0, 3'b000, 3'b000, 3'b000, 1);
        addVec(1, 3'b000, 3'b000, 0, 1, 0, 32'h0, 3'b010, 0, 3'b000, 3'b010, 3'b000, 1);
        addVec(1, 3'b000, 3'b000, 0, 0, 0, 32'h0, 3'b010, 0, 3'b000, 3'b000, 3'b000, 0);
        addVec(1, 3'b000, 3'b000, 0, 0, 0, 32'h0, 3'b000, 0, 3'b000, 3'b000, 3'b000, 0);

        resetDut();
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            #1;
            checkOutput("reset_grant",  64'(grant),         64'(0));
            checkOutput("reset_svalid", 64'(sdramReqValid), 64'(0));
        end

        foreach (vecs[i]) begin
            @(negedge clock);
            applyStimulus(vecs[i].boot, vecs[i].valid, vecs[i].rw, vecs[i].dRead,
                          vecs[i].last, vecs[i].rdV, vecs[i].rdData);
            #1;
            checkOutput($sformatf("vec%0d_grant", i),  64'(grant),         64'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d_svalid", i), 64'(sdramReqValid), 64'(vecs[i].expSValid));
            checkOutput($sformatf("vec%0d_dread", i),  64'(reqDataRead),   64'(vecs[i].expDRead));
            checkOutput($sformatf("vec%0d_last", i),   64'(reqLast),       64'(vecs[i].expLast));
            checkOutput($sformatf("vec%0d_rdv", i),    64'(reqRdValid),    64'(vecs[i].expRdV));
            checkOutput($sformatf("vec%0d_rddata", i), 64'(reqRdData),     64'(vecs[i].rdData));
            if (vecs[i].inBurst) begin
                owner = 0;
                for (int k = 0; k < N; k++) if (vecs[i].expGrant[k]) owner = k;
                checkOutput($sformatf("vec%0d_addr", i), 64'(sdramAddr),    64'(portAddr[owner]));
                checkOutput($sformatf("vec%0d_rw", i),   64'(sdramRw),      64'(vecs[i].rw[owner]));
                checkOutput($sformatf("vec%0d_data", i), 64'(sdramDataOut), 64'(portData[owner]));
            end
        end

        // Reset asserted mid-burst must drop the downstream valid immediately.
        @(negedge clock);
        applyStimulus(1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clock);
        #1;
        checkOutput("midrst_grant_before",  64'(grant),         64'(3'b100));
        checkOutput("midrst_svalid_before", 64'(sdramReqValid), 64'(1));
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_svalid_after", 64'(sdramReqValid), 64'(0));
        checkOutput("midrst_grant_after",  64'(grant),         64'(0));
        resetDut();

        // Round-robin with every port requesting continuously.
        applyStimulus(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        for (int b = 0; b < 6; b++) begin
            found = 1'b0;
            got   = '0;
            for (int t = 0; t < 10 && !found; t++) begin
                @(negedge clock);
                sdramLast = 1'b0;
                #1;
                if (grant != '0 && sdramReqValid) begin
                    found     = 1'b1;
                    got       = grant;
                    sdramLast = 1'b1;
                end
            end
            checkOutput($sformatf("rr%0d_granted", b), 64'(found), 64'(1));
            checkOutput($sformatf("rr%0d_owner", b),   64'(got),   64'(3'b001 << (b % 3)));
        end

        // Randomized traffic against the behavioural model.
        resetDut();
        rv = '0;
        for (int k = 0; k < N; k++) afterLast[k] = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            for (int k = 0; k < N; k++) begin
                if (afterLast[k] == 2) begin
                    rv[k] = 1'b0;
                    afterLast[k] = 0;
                end else if (afterLast[k] == 1) begin
                    afterLast[k] = 2;
                end else if (!rv[k] && $urandom_range(0, 2) == 0) begin
                    rv[k] = 1'b1;
                end
                portAddr[k] = AW'($urandom);
                portData[k] = $urandom;
            end
            applyStimulus($urandom_range(0, 9) > 2, rv, N'($urandom), 1'($urandom),
                          $urandom_range(0, 3) == 0, 1'($urandom), $urandom);
            #1;
            for (int k = 0; k < N; k++) begin
                if (mOwner == k && !mRelease && sdramLast) afterLast[k] = 1;
            end
            modelCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
